digital_tube: RTL and testbench
===============================

// Module: digital_tube
// PURPOSE
//  Bus-writable output peripheral driving an 8-digit multiplexed common-anode 7-segment display.
//  Sits on the CPU bridge as a write-mostly device.
//  Holds a 32-bit hex value (8 nibbles) and a control register.
//  Scans one digit at a time, with a one-cycle dead time between digits.
// PARAMETERS
//  SCAN_DIV   50000  clk cycles per digit slot (>=2)
//  BLINK_DIV  64     full 8-digit scans per blink half-period (>=1, TUBE_BLINK_EN only)
// PORTS
//  clk        in   1   system clock, all state on posedge
//  reset      in   1   asynchronous, active-low reset
//  Addr       in   2   word address [3:2]: 0=DATA, 1=CTRL, 2/3 unmapped
//  WE         in   1   write strobe, sampled on posedge clk
//  BE         in   4   byte enables for WriteData
//  WriteData  in   32  bus write data
//  ReadData   out  32  combinational readback of addressed register; 0 for Addr 2/3
//  seg_n      out  8   active-low segments {dp,g,f,e,d,c,b,a}, registered
//  sel_n      out  8   active-low digit selects, bit i = digit i (nibble i), registered
// BEHAVIOUR
//  - Registers
//    - DATA[31:0]: nibble i is shown on digit i.
//    - CTRL[7:0]: digit enable mask. CTRL[15:8]: dp mask.
//    - CTRL[23:16]: blink mask. CTRL[31:24]: reserved, reads 0.
//  - Reset values (reset low, immediate)
//    - DATA=0, CTRL=32'h000000FF.
//    - Prescaler=0, idx=0, dead=0, blink phase=0.
//    - sel_n=8'hFF, seg_n=8'hFF.
//  - Write
//    - On posedge with WE=1, each byte k with BE[k]=1 is updated.
//    - Writes to Addr 2/3 and to reserved bits are ignored.
//    - A write is visible on ReadData the next cycle, and on seg_n/sel_n within 1 cycle when that digit is active.
//  - Scan
//    - The prescaler counts 0..SCAN_DIV-1 and wraps.
//    - At the terminal count, idx advances 0->1->..->7->0 and the dead flag is set for 1 cycle.
//  - Output register, every cycle
//    - If dead=1, or CTRL[idx]=0, or the digit is blink-blanked: sel_n=8'hFF, seg_n=8'hFF.
//    - Otherwise sel_n=~(8'b1<<idx), seg_n={~CTRL[8+idx], hex7(DATA[4*idx+:4])}.
//  - hex7, active-low {g..a}, nibble 0..F:
//    40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E
//  - Simultaneous write and idx advance: the output uses the pre-write value this cycle and the new value next cycle.
//  - Reset mid-scan: outputs blank at once; scan restarts at digit 0 after release.
// CONFIGURATION
//  TUBE_BLINK_EN defined:
//   - A scan counter counts completed idx 7->0 wraps.
//   - Every BLINK_DIV wraps, the blink phase toggles.
//   - When phase=1, digits with CTRL[16+idx]=1 are blanked as if disabled.
//  TUBE_BLINK_EN undefined:
//   - No blink logic.
//   - CTRL[23:16] is not stored, reads 0, and writes to it are ignored.
// TESTING  (SCAN_DIV=4, BLINK_DIV=2)
//  1. reset low mid-scan
//     -> sel_n=FF, seg_n=FF, ReadData(Addr0)=0, ReadData(Addr1)=000000FF.
//  2. write DATA=32'h76543210, BE=F, then run 40 cycles
//     -> sel_n cycles FE,FD,..,7F, each held 3 cycles plus 1 blank (FF) cycle.
//     -> seg_n = C0,F9,A4,B0,99,92,82,F8 on the matching digit.
//  3. write BE=4'b0001 data 32'hFFFFFFAB to DATA=12345678
//     -> DATA reads 123456AB; digit0 shows B (seg_n=83), digit1 shows A (88).
//  4. write CTRL=32'h0000_0101
//     -> only digit 0 is lit, with dp on (seg_n[7]=0); sel_n=FF in the other 7 slots.
//  5. write Addr=2 WE=1 data FFFFFFFF
//     -> DATA and CTRL are unchanged; ReadData(Addr2)=0.
//  6. [TUBE_BLINK_EN] CTRL=32'h00FF00FF
//     -> all digits lit for 2 scans (64 cycles), then blank for 2 scans, repeating.
//     -> Without the macro, CTRL reads 000000FF and nothing blinks.

Source files
------------

// File: rtl/digital_tube.sv
// Bus-writable 8-digit multiplexed common-anode 7-segment driver with DATA/CTRL registers.
// Optional blink support is compiled in when TUBE_BLINK_EN is defined.
module digital_tube #(
    parameter int SCAN_DIV  = 50000
`ifdef TUBE_BLINK_EN
    ,
    parameter int BLINK_DIV = 64
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  seg_n,
    output logic [7:0]  sel_n
);

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_CTRL = 2'd1
    } addr_e;

    localparam int            PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [31:0]   data_q;
    logic [7:0]    en_q;
    logic [7:0]    dp_q;
    logic [7:0]    blink_mask;
    logic [PW-1:0] presc_q;
    logic [2:0]    idx_q;
    logic          dead_q;
    logic          blanked;
    logic          terminal;
    logic [7:0]    sel_d;
    logic [7:0]    seg_d;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Register file: byte-lane writes, unmapped addresses and reserved bits dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            data_q <= '0;
            en_q   <= 8'hFF;
            dp_q   <= 8'h00;
        end else if (WE) begin
            if (Addr == ADDR_DATA) begin
                for (int k = 0; k < 4; k++) begin
                    if (BE[k]) data_q[8*k +: 8] <= WriteData[8*k +: 8];
                end
            end
            if (Addr == ADDR_CTRL) begin
                if (BE[0]) en_q <= WriteData[7:0];
                if (BE[1]) dp_q <= WriteData[15:8];
            end
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves ReadData unassigned (no latch).
        ReadData = '0;
        case (Addr)
            ADDR_DATA: ReadData = data_q;
            ADDR_CTRL: ReadData = {8'h00, blink_mask, dp_q, en_q};
            default:   ReadData = '0;
        endcase
    end

    assign terminal = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            dead_q  <= 1'b0;
        end else begin
            presc_q <= terminal ? '0 : presc_q + 1'b1;
            if (terminal) idx_q <= idx_q + 3'd1;
            dead_q  <= terminal;
        end
    end

`ifdef TUBE_BLINK_EN
    localparam int            SW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(BLINK_DIV - 1);

    logic [7:0]    blink_q;
    logic [SW-1:0] scan_cnt_q;
    logic          phase_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_q    <= 8'h00;
            scan_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            if (WE && Addr == ADDR_CTRL && BE[2]) blink_q <= WriteData[23:16];
            // One full scan completes when the digit index wraps 7 -> 0.
            if (terminal && idx_q == 3'd7) begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_q <= '0;
                    phase_q    <= ~phase_q;
                end else begin
                    scan_cnt_q <= scan_cnt_q + 1'b1;
                end
            end
        end
    end

    assign blink_mask = blink_q;
    assign blanked    = phase_q & blink_q[idx_q];
`else
    assign blink_mask = 8'h00;
    assign blanked    = 1'b0;
`endif

    always_comb begin
        sel_d = 8'hFF;
        seg_d = 8'hFF;
        if (!dead_q && en_q[idx_q] && !blanked) begin
            sel_d = ~(8'b1 << idx_q);
            seg_d = {~dp_q[idx_q], hex7(data_q[{idx_q, 2'b00} +: 4])};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_n <= 8'hFF;
            seg_n <= 8'hFF;
        end else begin
            sel_n <= sel_d;
            seg_n <= seg_d;
        end
    end

endmodule

// File: tb/tb_digital_tube.sv
// Scoreboard bench for digital_tube at SCAN_DIV=4 (BLINK_DIV=2 when TUBE_BLINK_EN is defined).
// Stimulus pushes expected digit slots; a negedge monitor pops one per lit slot start.
module tb_digital_tube;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  Addr = 2'd0;
    logic        WE = 1'b0;
    logic [3:0]  BE = 4'h0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic [7:0]  seg_n;
    logic [7:0]  sel_n;

    digital_tube #(
        .SCAN_DIV(4)
`ifdef TUBE_BLINK_EN
        ,
        .BLINK_DIV(2)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Addr     (Addr),
        .WE       (WE),
        .BE       (BE),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .seg_n    (seg_n),
        .sel_n    (sel_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] seg;
    } slot_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    slot_t exp_q[$];
    slot_t mon_e;
    bit    armed  = 1'b0;
    bit    synced = 1'b0;
    logic [7:0] mon_prev = 8'hFF;

`ifdef TUBE_BLINK_EN
    localparam logic [31:0] CTRL6_EXP = 32'h00FF00FF;
    localparam int          RUN6_EXP  = 65;
`else
    localparam logic [31:0] CTRL6_EXP = 32'h000000FF;
    localparam int          RUN6_EXP  = 1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a slot starts when sel_n leaves all-off; sync on the first digit-0 slot.
    always @(negedge clk) begin
        if (armed && mon_prev == 8'hFF && sel_n != 8'hFF) begin
            if (!synced && sel_n == 8'hFE) synced = 1'b1;
            if (synced && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("slot sel_n", {24'h0, sel_n}, {24'h0, mon_e.sel});
                check("slot seg_n", {24'h0, seg_n}, {24'h0, mon_e.seg});
            end
        end
        mon_prev = sel_n;
    end

    task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        Addr = a; WE = 1'b1; BE = be; WriteData = d;
        @(negedge clk);
        WE = 1'b0; BE = 4'h0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(name, ReadData, exp);
    endtask

    task automatic wait_start(input logic [7:0] target, output bit found);
        logic [7:0] prev;
        found = 1'b0;
        prev  = sel_n;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prev == 8'hFF && sel_n == target) begin
                found = 1'b1;
                break;
            end
            prev = sel_n;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check(name, exp_q.size(), 0);
        armed  = 1'b0;
        synced = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seg_t2 [8];
        logic [7:0] seg_t3 [8];
        logic [7:0] e8;
        bit         found;
        int         lit_cnt;
        int         odd_cnt;
        int         run;
        int         max_run;

        seg_t2 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        seg_t3 = '{8'h83, 8'h88, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

        // 1: reset asserted mid-scan after registers were changed
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_write(2'd0, 4'hF, 32'hDEADBEEF);
        bus_write(2'd1, 4'hF, 32'h0000_FF0F);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset sel_n", {24'h0, sel_n}, 32'h0000_00FF);
        check("reset seg_n", {24'h0, seg_n}, 32'h0000_00FF);
        read_check("reset DATA", 2'd0, 32'h0000_0000);
        read_check("reset CTRL", 2'd1, 32'h0000_00FF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel_n != 8'hFF) begin
                found = 1'b1;
                break;
            end
        end
        check("restart lit", {31'h0, found}, 32'h1);
        check("restart sel_n", {24'h0, sel_n}, 32'h0000_00FE);
        check("restart seg_n", {24'h0, seg_n}, 32'h0000_00C0);

        // 2: full scan of 76543210, slot timing 3 lit + 1 blank
        bus_write(2'd0, 4'hF, 32'h76543210);
        read_check("t2 DATA", 2'd0, 32'h76543210);
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < 8; d++) exp_q.push_back('{sel: ~(8'b1 << d), seg: seg_t2[d]});
        armed = 1'b1;
        wait_start(8'hFE, found);
        check("t2 sync", {31'h0, found}, 32'h1);
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            e8 = (c % 4 == 3) ? 8'hFF : ~(8'b1 << (c / 4));
            check("t2 sel_n timing", {24'h0, sel_n}, {24'h0, e8});
        end
        drain("t2 scoreboard drained");

        // 3: byte-lane write
        bus_write(2'd0, 4'hF, 32'h12345678);
        bus_write(2'd0, 4'b0001, 32'hFFFFFFAB);
        read_check("t3 DATA", 2'd0, 32'h123456AB);
        for (int d = 0; d < 8; d++) exp_q.push_back('{sel: ~(8'b1 << d), seg: seg_t3[d]});
        armed = 1'b1;
        drain("t3 scoreboard drained");

        // 4: only digit 0 enabled, dp on
        bus_write(2'd1, 4'hF, 32'h0000_0101);
        read_check("t4 CTRL", 2'd1, 32'h0000_0101);
        exp_q.push_back('{sel: 8'hFE, seg: 8'h03});
        exp_q.push_back('{sel: 8'hFE, seg: 8'h03});
        armed = 1'b1;
        drain("t4 scoreboard drained");
        lit_cnt = 0;
        odd_cnt = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (sel_n == 8'hFE) lit_cnt++;
            else if (sel_n != 8'hFF) odd_cnt++;
        end
        check("t4 digit0 lit cycles", lit_cnt, 6);
        check("t4 other digits lit", odd_cnt, 0);

        // 5: unmapped write and reserved CTRL bits
        bus_write(2'd2, 4'hF, 32'hFFFFFFFF);
        bus_write(2'd3, 4'hF, 32'hFFFFFFFF);
        read_check("t5 DATA", 2'd0, 32'h123456AB);
        read_check("t5 CTRL", 2'd1, 32'h0000_0101);
        read_check("t5 Addr2", 2'd2, 32'h0000_0000);
        read_check("t5 Addr3", 2'd3, 32'h0000_0000);
        bus_write(2'd1, 4'hF, 32'hFF00_0101);
        read_check("t5 CTRL reserved", 2'd1, 32'h0000_0101);

        // 6: blink mask; longest all-off run reveals blanked scans
        bus_write(2'd1, 4'hF, 32'h00FF00FF);
        read_check("t6 CTRL", 2'd1, CTRL6_EXP);
        run = 0;
        max_run = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (sel_n == 8'hFF) run++;
            else run = 0;
            if (run > max_run) max_run = run;
        end
        check("t6 longest blank run", max_run, RUN6_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
